// File: rtl/alu_nibble_sequencer_if.sv
// Operation request / result handshake bundle for alu_nibble_sequencer.
// master = operation source and result consumer, slave = the sequencer.
interface alu_nibble_sequencer_if #(
  parameter int WORDS = 4
);
  logic                 in_valid;
  logic                 in_ready;
  logic [4*WORDS-1:0]   in_a;
  logic [4*WORDS-1:0]   in_b;
  logic [3:0]           in_s;
  logic                 in_m;
  logic                 in_ci_n;
  logic                 out_valid;
  logic                 out_ready;
  logic [4*WORDS-1:0]   out_y;
  logic                 out_co_n;
  logic                 out_aeqb;

  modport master (
    output in_valid, in_a, in_b, in_s, in_m, in_ci_n, out_ready,
    input  in_ready, out_valid, out_y, out_co_n, out_aeqb
  );

  modport slave (
    input  in_valid, in_a, in_b, in_s, in_m, in_ci_n, out_ready,
    output in_ready, out_valid, out_y, out_co_n, out_aeqb
  );
endinterface

// File: rtl/alu_nibble_sequencer.sv
// Runs WORDS-nibble operations through one shared 74181-style ALU slice, LS nibble first.
// Optional macro ALU_SEQ_LOOKAHEAD_EN adds the out_p_n group-propagate output.
module alu_nibble_sequencer #(
  parameter int WORDS = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  alu_nibble_sequencer_if.slave bus,
  output logic [3:0]           alu_a,
  output logic [3:0]           alu_b,
  output logic [3:0]           alu_s,
  output logic                 alu_m,
  output logic                 alu_ci_n,
  input  logic [3:0]           alu_y,
  input  logic                 alu_co_n,
  input  logic                 alu_aeqb,
`ifdef ALU_SEQ_LOOKAHEAD_EN
  input  logic                 alu_p,
  input  logic                 alu_q,
  output logic                 out_p_n
`else
  input  logic                 alu_p,
  input  logic                 alu_q
`endif
);

  localparam int W  = 4 * WORDS;
  localparam int IW = $clog2(WORDS);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state;
  logic [W-1:0]    a_reg;
  logic [W-1:0]    b_reg;
  logic [W-1:0]    y_reg;
  logic [3:0]      s_reg;
  logic            m_reg;
  logic [IW-1:0]   idx;
  logic            carry_n;
  logic            aeqb_acc;
  logic            ready_reg;
  logic            valid_reg;

`ifdef ALU_SEQ_LOOKAHEAD_EN
  logic            lk;
  logic            unused_inputs;
  assign unused_inputs = alu_q;
`else
  logic            unused_inputs;
  assign unused_inputs = alu_p ^ alu_q;
`endif

  // The carry ripples through carry_n between slices, in logic mode too.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      ready_reg <= 1'b1;
      valid_reg <= 1'b0;
      a_reg     <= '0;
      b_reg     <= '0;
      y_reg     <= '0;
      s_reg     <= 4'h0;
      m_reg     <= 1'b0;
      idx       <= '0;
      carry_n   <= 1'b1;
      aeqb_acc  <= 1'b0;
`ifdef ALU_SEQ_LOOKAHEAD_EN
      lk        <= 1'b0;
`endif
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.in_valid) begin
            a_reg     <= bus.in_a;
            b_reg     <= bus.in_b;
            s_reg     <= bus.in_s;
            m_reg     <= bus.in_m;
            carry_n   <= bus.in_ci_n;
            idx       <= '0;
            aeqb_acc  <= 1'b1;
`ifdef ALU_SEQ_LOOKAHEAD_EN
            lk        <= 1'b1;
`endif
            ready_reg <= 1'b0;
            state     <= RUN;
          end
        end
        RUN: begin
          y_reg[4*idx +: 4] <= alu_y;
          carry_n           <= alu_co_n;
          aeqb_acc          <= aeqb_acc & alu_aeqb;
`ifdef ALU_SEQ_LOOKAHEAD_EN
          lk                <= lk & alu_p;
`endif
          if (idx == IW'(WORDS - 1)) begin
            valid_reg <= 1'b1;
            state     <= DONE;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            valid_reg <= 1'b0;
            ready_reg <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          valid_reg <= 1'b0;
          ready_reg <= 1'b1;
          state     <= IDLE;
        end
      endcase
    end
  end

  // Outside RUN the ALU sees a quiet, no-carry-in pattern.
  always_comb begin
    alu_a    = 4'h0;
    alu_b    = 4'h0;
    alu_s    = 4'h0;
    alu_m    = 1'b0;
    alu_ci_n = 1'b1;
    if (state == RUN) begin
      alu_a    = a_reg[4*idx +: 4];
      alu_b    = b_reg[4*idx +: 4];
      alu_s    = s_reg;
      alu_m    = m_reg;
      alu_ci_n = carry_n;
    end
  end

  assign bus.in_ready  = ready_reg;
  assign bus.out_valid = valid_reg;
  assign bus.out_y     = y_reg;
  assign bus.out_co_n  = carry_n;
  assign bus.out_aeqb  = aeqb_acc;
`ifdef ALU_SEQ_LOOKAHEAD_EN
  assign out_p_n       = ~lk;
`endif

endmodule

// File: tb/tb_alu_nibble_sequencer.sv
// Bench for alu_nibble_sequencer: behavioural 74181 slice, wide-arithmetic reference
// model with a per-cycle compare process, directed test-plan cases and random operations.
module tb_alu_nibble_sequencer;

  localparam int WORDS = 4;
  localparam int W     = 4 * WORDS;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  alu_nibble_sequencer_if #(.WORDS(WORDS)) bus ();

  logic [3:0] alu_a, alu_b, alu_s, alu_y;
  logic       alu_m, alu_ci_n, alu_co_n, alu_aeqb, alu_p, alu_q;
`ifdef ALU_SEQ_LOOKAHEAD_EN
  logic       out_p_n;
`endif

  alu_nibble_sequencer #(.WORDS(WORDS)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus),
    .alu_a    (alu_a),
    .alu_b    (alu_b),
    .alu_s    (alu_s),
    .alu_m    (alu_m),
    .alu_ci_n (alu_ci_n),
    .alu_y    (alu_y),
    .alu_co_n (alu_co_n),
    .alu_aeqb (alu_aeqb),
`ifdef ALU_SEQ_LOOKAHEAD_EN
    .alu_p    (alu_p),
    .alu_q    (alu_q),
    .out_p_n  (out_p_n)
`else
    .alu_p    (alu_p),
    .alu_q    (alu_q)
`endif
  );

  int checks   = 0;
  int failures = 0;

  // 74181 arithmetic is F = X plus Y plus carry, with X/Y chosen by S.
  function automatic logic [W-1:0] xTerm(input logic [W-1:0] a, input logic [W-1:0] b,
                                          input logic [3:0] s);
    return a | (s[0] ? b : '0) | (s[1] ? ~b : '0);
  endfunction

  function automatic logic [W-1:0] yTerm(input logic [W-1:0] a, input logic [W-1:0] b,
                                          input logic [3:0] s);
    return a & ((s[3] ? b : '0) | (s[2] ? ~b : '0));
  endfunction

  function automatic logic [W-1:0] logicF(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic [3:0] s);
    case (s)
      4'd0:    return ~a;
      4'd1:    return ~(a | b);
      4'd2:    return ~a & b;
      4'd3:    return '0;
      4'd4:    return ~(a & b);
      4'd5:    return ~b;
      4'd6:    return a ^ b;
      4'd7:    return a & ~b;
      4'd8:    return ~a | b;
      4'd9:    return ~(a ^ b);
      4'd10:   return b;
      4'd11:   return a & b;
      4'd12:   return '1;
      4'd13:   return a | ~b;
      4'd14:   return a | b;
      default: return a;
    endcase
  endfunction

  function automatic logic [W:0] arithSum(input logic [W-1:0] a, input logic [W-1:0] b,
                                          input logic [3:0] s, input logic ci_n);
    return {1'b0, xTerm(a, b, s)} + {1'b0, yTerm(a, b, s)} + {{W{1'b0}}, ~ci_n};
  endfunction

  function automatic logic [W-1:0] refY(input logic [W-1:0] a, input logic [W-1:0] b,
                                        input logic [3:0] s, input logic m, input logic ci_n);
    logic [W:0] sum;
    sum = arithSum(a, b, s, ci_n);
    return m ? logicF(a, b, s) : sum[W-1:0];
  endfunction

  function automatic logic refCoN(input logic [W-1:0] a, input logic [W-1:0] b,
                                  input logic [3:0] s, input logic ci_n);
    logic [W:0] sum;
    sum = arithSum(a, b, s, ci_n);
    return ~sum[W];
  endfunction

  // Active-low carry entering slice c: the carry out of the low 4*c bits of the wide sum.
  function automatic logic sliceCinN(input logic [W-1:0] a, input logic [W-1:0] b,
                                     input logic [3:0] s, input logic ci_n, input int c);
    logic [W:0] mask;
    logic [W:0] sum;
    if (c == 0) return ci_n;
    mask = ((W+1)'(1) << (4 * c)) - (W+1)'(1);
    sum  = ({1'b0, xTerm(a, b, s)} & mask) + ({1'b0, yTerm(a, b, s)} & mask)
           + {{W{1'b0}}, ~ci_n};
    return ~sum[4*c];
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural 4-bit ALU slice driven by the sequencer.
  logic [W-1:0] za, zb, lf, xw, yw;
  logic [3:0]   xn, yn;
  logic [4:0]   s5, g5;
  always_comb begin
    za       = {{(W-4){1'b0}}, alu_a};
    zb       = {{(W-4){1'b0}}, alu_b};
    lf       = logicF(za, zb, alu_s);
    xw       = xTerm(za, zb, alu_s);
    yw       = yTerm(za, zb, alu_s);
    xn       = xw[3:0];
    yn       = yw[3:0];
    s5       = {1'b0, xn} + {1'b0, yn} + {4'b0, ~alu_ci_n};
    g5       = {1'b0, xn} + {1'b0, yn};
    alu_y    = alu_m ? lf[3:0] : s5[3:0];
    alu_co_n = ~s5[4];
    alu_aeqb = (alu_y == 4'hF);
    alu_p    = &xn;
    alu_q    = g5[4];
  end

  // Protocol-level model: busy for WORDS edges after accept, then done until out_ready.
  logic         m_busy = 1'b0;
  logic         m_done = 1'b0;
  int           m_cnt  = 0;
  logic [W-1:0] m_a    = '0;
  logic [W-1:0] m_b    = '0;
  logic [3:0]   m_s    = 4'h0;
  logic         m_m    = 1'b0;
  logic         m_ci   = 1'b1;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy <= 1'b0;
      m_done <= 1'b0;
      m_cnt  <= 0;
    end else if (!m_busy && !m_done) begin
      if (bus.in_valid) begin
        m_busy <= 1'b1;
        m_cnt  <= 0;
        m_a    <= bus.in_a;
        m_b    <= bus.in_b;
        m_s    <= bus.in_s;
        m_m    <= bus.in_m;
        m_ci   <= bus.in_ci_n;
      end
    end else if (m_busy) begin
      if (m_cnt == WORDS - 1) begin
        m_busy <= 1'b0;
        m_done <= 1'b1;
      end
      m_cnt <= m_cnt + 1;
    end else if (bus.out_ready) begin
      m_done <= 1'b0;
    end
  end

  // Per-cycle compare of every DUT output against the model.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      checkOutput("in_ready", 32'(bus.in_ready), 32'(!(m_busy || m_done)));
      checkOutput("out_valid", 32'(bus.out_valid), 32'(m_done));
      if (m_done) begin
        checkOutput("out_y", 32'(bus.out_y), 32'(refY(m_a, m_b, m_s, m_m, m_ci)));
        checkOutput("out_co_n", 32'(bus.out_co_n), 32'(refCoN(m_a, m_b, m_s, m_ci)));
        checkOutput("out_aeqb", 32'(bus.out_aeqb), 32'(&refY(m_a, m_b, m_s, m_m, m_ci)));
`ifdef ALU_SEQ_LOOKAHEAD_EN
        checkOutput("out_p_n", 32'(out_p_n), 32'(~&xTerm(m_a, m_b, m_s)));
`endif
      end
      if (m_busy) begin
        checkOutput("alu_a", 32'(alu_a), 32'(m_a[4*m_cnt +: 4]));
        checkOutput("alu_b", 32'(alu_b), 32'(m_b[4*m_cnt +: 4]));
        checkOutput("alu_s_m", 32'({alu_s, alu_m}), 32'({m_s, m_m}));
        checkOutput("alu_ci_n", 32'(alu_ci_n), 32'(sliceCinN(m_a, m_b, m_s, m_ci, m_cnt)));
      end else begin
        checkOutput("alu_idle", 32'({alu_a, alu_b, alu_s, alu_m, alu_ci_n}), 32'h0001);
      end
    end
  end

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_in_ready"}, 32'(bus.in_ready), 32'd1);
    checkOutput({tag, "_out_valid"}, 32'(bus.out_valid), 32'd0);
    checkOutput({tag, "_out_y"}, 32'(bus.out_y), 32'd0);
    checkOutput({tag, "_out_co_n"}, 32'(bus.out_co_n), 32'd1);
    checkOutput({tag, "_out_aeqb"}, 32'(bus.out_aeqb), 32'd0);
    checkOutput({tag, "_alu"}, 32'({alu_a, alu_b, alu_s, alu_m, alu_ci_n}), 32'h0001);
`ifdef ALU_SEQ_LOOKAHEAD_EN
    checkOutput({tag, "_out_p_n"}, 32'(out_p_n), 32'd1);
`endif
  endtask

  // Issue one operation, check latency, optional literal results, then hold/release out_ready.
  task automatic applyStimulus(input logic [W-1:0] a, input logic [W-1:0] b,
                               input logic [3:0] s, input logic m, input logic ci_n,
                               input int hold, input bit lit, input logic [W-1:0] exp_y,
                               input logic exp_co_n, input logic exp_aeqb, input bit lit_co);
    int  j;
    bit  acc;
    logic [W-1:0] want_y;
    want_y = lit ? exp_y : refY(a, b, s, m, ci_n);
    @(negedge clk);
    bus.in_a      = a;
    bus.in_b      = b;
    bus.in_s      = s;
    bus.in_m      = m;
    bus.in_ci_n   = ci_n;
    bus.in_valid  = 1'b1;
    bus.out_ready = (hold == 0);
    acc = 1'b0;
    for (int t = 0; t < 20; t++) begin
      if (bus.in_ready) begin
        acc = 1'b1;
        break;
      end
      @(negedge clk);
    end
    checkOutput("accept", 32'(acc), 32'd1);
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.in_a     = W'($urandom());
    bus.in_b     = W'($urandom());
    j = 0;
    while (!bus.out_valid && j < WORDS + 8) begin
      @(negedge clk);
      j++;
    end
    checkOutput("latency", 32'(j), 32'(WORDS));
    if (lit) begin
      checkOutput("lit_y", 32'(bus.out_y), 32'(exp_y));
      checkOutput("lit_aeqb", 32'(bus.out_aeqb), 32'(exp_aeqb));
      if (lit_co) checkOutput("lit_co_n", 32'(bus.out_co_n), 32'(exp_co_n));
    end
    if (hold > 0) begin
      bus.in_valid = 1'b1;
      repeat (hold) begin
        @(negedge clk);
        checkOutput("hold_valid", 32'(bus.out_valid), 32'd1);
        checkOutput("hold_ready", 32'(bus.in_ready), 32'd0);
        checkOutput("hold_y", 32'(bus.out_y), 32'(want_y));
      end
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
    end
    @(negedge clk);
    checkOutput("back_idle", 32'({bus.in_ready, bus.out_valid}), 32'b10);
    bus.out_ready = 1'($urandom_range(0, 1));
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.in_s      = 4'h0;
    bus.in_m      = 1'b0;
    bus.in_ci_n   = 1'b1;
    bus.out_ready = 1'b0;

    // Pin the reference model on hand-computed cases.
    checkOutput("model_add", 32'(refY(16'h00FF, 16'h0001, 4'b1001, 1'b0, 1'b1)), 32'h0100);
    checkOutput("model_wrap", 32'(refY(16'hFFFF, 16'h0001, 4'b1001, 1'b0, 1'b1)), 32'h0000);
    checkOutput("model_wrap_co", 32'(refCoN(16'hFFFF, 16'h0001, 4'b1001, 1'b1)), 32'd0);
    checkOutput("model_sub", 32'(refY(16'h1234, 16'h1234, 4'b0110, 1'b0, 1'b1)), 32'hFFFF);
    checkOutput("model_xor", 32'(refY(16'hF0F0, 16'hFF00, 4'b0110, 1'b1, 1'b0)), 32'h0FF0);
    checkOutput("model_cin2", 32'(sliceCinN(16'hFFFF, 16'h0001, 4'b1001, 1'b1, 2)), 32'd0);

    #12;
    checkResetValues("reset");
    @(negedge clk);
    rst_n = 1'b1;

    applyStimulus(16'h00FF, 16'h0001, 4'b1001, 1'b0, 1'b1, 0, 1'b1, 16'h0100, 1'b1, 1'b0, 1'b1);
    applyStimulus(16'hFFFF, 16'h0001, 4'b1001, 1'b0, 1'b1, 1, 1'b1, 16'h0000, 1'b0, 1'b0, 1'b1);
    applyStimulus(16'h1234, 16'h1234, 4'b0110, 1'b0, 1'b1, 0, 1'b1, 16'hFFFF, 1'b1, 1'b1, 1'b1);
    applyStimulus(16'h1235, 16'h1234, 4'b0110, 1'b0, 1'b1, 2, 1'b1, 16'h0000, 1'b0, 1'b0, 1'b1);
    applyStimulus(16'hF0F0, 16'hFF00, 4'b0110, 1'b1, 1'b0, 0, 1'b1, 16'h0FF0, 1'b1, 1'b0, 1'b0);
    applyStimulus(16'hF0F0, 16'hFF00, 4'b0110, 1'b1, 1'b1, 5, 1'b1, 16'h0FF0, 1'b1, 1'b0, 1'b0);

    for (int n = 0; n < 40; n++) begin
      applyStimulus(W'($urandom()), W'($urandom()), 4'($urandom_range(0, 15)),
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    $urandom_range(0, 3), 1'b0, '0, 1'b1, 1'b0, 1'b0);
      repeat ($urandom_range(0, 2)) begin
        @(negedge clk);
        bus.out_ready = 1'($urandom_range(0, 1));
      end
    end

    // Abort an operation at idx=2 with an asynchronous reset.
    @(negedge clk);
    bus.out_ready = 1'b0;
    bus.in_a      = 16'hFFFF;
    bus.in_b      = 16'h0001;
    bus.in_s      = 4'b1001;
    bus.in_m      = 1'b0;
    bus.in_ci_n   = 1'b1;
    bus.in_valid  = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checkResetValues("abort");
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(16'h00FF, 16'h0001, 4'b1001, 1'b0, 1'b1, 0, 1'b1, 16'h0100, 1'b1, 1'b0, 1'b1);

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
